divider: RTL
============

# divider

Multicycle 32-bit signed integer divider for the processor's execute stage, sharing the ALU's operand buses. It accepts a one-cycle start pulse and latched operands, then runs a 32-iteration restoring non-performing shift/subtract loop on operand magnitudes. It returns a quotient truncated toward zero, a remainder, a divide-by-zero exception flag and a one-cycle ready pulse. The pipeline stalls on `busy` until `data_resultRDY`.

## Interface
Parameters: none; width fixed at 32.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ctrl_DIV`  in  1  start pulse, sampled on the rising edge of `clock`.
- `data_operandA`  in  32  dividend, two's complement, sampled only on the start edge.
- `data_operandB`  in  32  divisor, two's complement, sampled only on the start edge.
- `data_result`  out  32  quotient, registered.
- `data_remainder`  out  32  remainder, registered.
- `data_exception`  out  1  divide by zero.
- `data_resultRDY`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while an operation is in flight.

## Operation
- States:
  - IDLE: waits for a start.
  - RUN: performs the iterations; holds a 6-bit counter.
  - DONE: single cycle.
- Start:
  - On any edge with `ctrl_DIV=1`, in any state, capture |A| and |B| (unsigned 32-bit; |0x80000000| = 0x80000000).
  - Also capture `signQ = A[31]^B[31]` and `signR = A[31]`.
  - Clear the remainder accumulator and the counter, then go to RUN.
- Divide by zero: if the captured B is 0, go directly to DONE with `data_exception=1`, `data_result=0` and `data_remainder=0`.
- Iteration, one per cycle in RUN:
  - Shift {R,Q} left by 1, bringing the next dividend bit into Q[0].
  - Compute `R-|B|` in 33 bits. If the difference is non-negative, R takes the difference and Q[0]=1. Otherwise R is kept and Q[0]=0.
  - The counter increments. After the 32nd iteration, go to DONE.
- DONE:
  - Register `data_result = signQ ? -Q : Q` and `data_remainder = signR ? -R : R`, both mod 2^32.
  - Assert `data_resultRDY` for this cycle only, then return to IDLE.
- Overflow: 0x80000000 / 0xFFFFFFFF produces `data_result=0x80000000` and `data_remainder=0`, with no exception.
- `data_result`, `data_remainder` and `data_exception` hold their values until the next DONE or reset.
- `busy` is high in RUN and DONE and low in IDLE.
- Restart: `ctrl_DIV` during RUN or DONE aborts the current operation. It produces no ready pulse for the aborted operation and restarts with the new operands.
- Reset (`reset_n=0`), asynchronous and taking effect at any time including mid-operation:
  - State goes to IDLE.
  - All outputs go to 0: `data_result`, `data_remainder`, `data_exception`, `data_resultRDY`, `busy`.
  - Internal registers are cleared.

## Timing
- Start edge E0: the edge on which `ctrl_DIV` is sampled high.
- Normal operation:
  - Iterations occur on edges E1..E32.
  - DONE outputs register on E33, so `data_resultRDY` is high from E33 to E34. Latency is 33 cycles.
  - `busy` rises after E0 and falls after E34.
- Divide by zero: result, exception and ready register on E1, so latency is 1 cycle.
- `data_exception` updates on every DONE: it is 1 for divide-by-zero and 0 otherwise.
- Operand buses may change freely after E0.
- `ctrl_DIV` held high for several cycles restarts on every edge. Only the final start completes.
- Back-to-back operation: a start on the same edge as DONE aborts that DONE, so no ready pulse is produced for the aborted operation.

## Test plan
- Basic division: reset, then A=100, B=7, pulse start → after 33 cycles, `data_result=14`, `data_remainder=2`, RDY pulse exactly one cycle wide, exception=0.
- Signed truncation: A=-100, B=7 → result=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Then A=100, B=-7 → result=-14, remainder=2.
- Divide by zero: A=7, B=0 → RDY and exception high after 1 cycle, result=0. A following 9/3 → result=3 with exception back to 0.
- Extremes:
  - A=0x80000000, B=0xFFFFFFFF → result=0x80000000, remainder=0, exception=0.
  - A=0x80000000, B=1 → result=0x80000000.
  - A=5, B=9 → result=0, remainder=5.
- Restart mid-operation: start 1000/3, then at cycle 10 start 50/5 → exactly one RDY pulse, 33 cycles after the second start, with result=10 and remainder=0.
- Reset mid-operation: assert `reset_n=0` at cycle 20 of 1000/3 → all outputs go to 0 immediately, with no RDY pulse afterward. After release, 81/9 returns 9 with normal latency.

Source files
------------

// File: rtl/divider.sv
// Multicycle 32-bit signed divider: restoring shift/subtract on operand magnitudes,
// quotient truncated toward zero, remainder takes the sign of the dividend.
module divider (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic [31:0] data_remainder,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        sign_quo_q, sign_quo_d;
    logic        sign_rem_q, sign_rem_d;
    logic [31:0] result_q, result_d;
    logic [31:0] remainder_q, remainder_d;
    logic        exception_q, exception_d;
    logic        rdy_q, rdy_d;

    logic [32:0] rem_shift;
    logic [32:0] diff;

    // Magnitude modulo 2^32; the most negative value maps onto itself.
    function automatic logic [31:0] magnitude(input logic [31:0] x);
        return x[31] ? (32'd0 - x) : x;
    endfunction

    // Remainder stays below the divisor (<= 2^31), so the shifted value fits in 33 bits.
    assign rem_shift = {rem_q, quo_q[31]};
    assign diff      = rem_shift - {1'b0, dvs_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        sign_quo_d  = sign_quo_q;
        sign_rem_d  = sign_rem_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exception_d = exception_q;
        rdy_d       = 1'b0;

        if (ctrl_DIV) begin
            // A start always wins, aborting whatever is in flight.
            state_d    = StRun;
            cnt_d      = 6'd0;
            rem_d      = 32'd0;
            quo_d      = magnitude(data_operandA);
            dvs_d      = magnitude(data_operandB);
            sign_quo_d = data_operandA[31] ^ data_operandB[31];
            sign_rem_d = data_operandA[31];
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StRun: begin
                    if (dvs_q == 32'd0) begin
                        state_d     = StDone;
                        result_d    = 32'd0;
                        remainder_d = 32'd0;
                        exception_d = 1'b1;
                        rdy_d       = 1'b1;
                    end else if (cnt_q == 6'd32) begin
                        state_d     = StDone;
                        result_d    = sign_quo_q ? (32'd0 - quo_q) : quo_q;
                        remainder_d = sign_rem_q ? (32'd0 - rem_q) : rem_q;
                        exception_d = 1'b0;
                        rdy_d       = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                        if (!diff[32]) begin
                            rem_d = diff[31:0];
                            quo_d = {quo_q[30:0], 1'b1};
                        end else begin
                            rem_d = rem_shift[31:0];
                            quo_d = {quo_q[30:0], 1'b0};
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= 6'd0;
            rem_q       <= 32'd0;
            quo_q       <= 32'd0;
            dvs_q       <= 32'd0;
            sign_quo_q  <= 1'b0;
            sign_rem_q  <= 1'b0;
            result_q    <= 32'd0;
            remainder_q <= 32'd0;
            exception_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            sign_quo_q  <= sign_quo_d;
            sign_rem_q  <= sign_rem_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exception_q <= exception_d;
            rdy_q       <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exception_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q != StIdle);

endmodule
